// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               controller: controller state encoding and fill-target codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller state, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } pc_state_t;

    // fill_sel encodings
    localparam logic FILL_I = 1'b0;
    localparam logic FILL_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator. Flags when the instruction
//               in ID reads a register that the load currently in EX will
//               write. Register 0 is never a hazard source.
// Ports       : ID_rs, ID_rt         in  4  ID source register numbers
//               ID_rs_used/rt_used   in  1  source actually read
//               EX_MemRead           in  1  EX instruction is a load
//               EX_rd                in  4  EX destination register
//               lu                   out 1  load-use hazard
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] ID_rs,
    input  logic [3:0] ID_rt,
    input  logic       ID_rs_used,
    input  logic       ID_rt_used,
    input  logic       EX_MemRead,
    input  logic [3:0] EX_rd,
    output logic       lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = ID_rs_used && (ID_rs == EX_rd);
    assign w_rt_hit = ID_rt_used && (ID_rt == EX_rd);
    assign lu       = EX_MemRead && (EX_rd != 4'd0) && (w_rs_hit || w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush controller for the 5-stage pipeline. Produces
//               pipeline-register write enables, IF_ID flush and ID_EX bubble,
//               sequences I-/D-cache fills over a single memory port, and
//               keeps a saturating stall-cycle counter.
// Ports       : clk, rst_n (async, active-low)
//               ID_rs/ID_rt/ID_rs_used/ID_rt_used/EX_MemRead/EX_rd  hazard in
//               ID_BranchTaken, IF_miss, MEM_miss, fill_done         events in
//               fill_req, fill_sel                                   fill out
//               PC/IF_ID/ID_EX/EX_MEM/MEM_WB _wen                    enables
//               IF_ID_flush, ID_EX_bubble                            squash
//               stall_count [CNT_W]                                  perf
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ID_rs,
    input  logic [3:0]       ID_rt,
    input  logic             ID_rs_used,
    input  logic             ID_rt_used,
    input  logic             EX_MemRead,
    input  logic [3:0]       EX_rd,
    input  logic             ID_BranchTaken,
    input  logic             IF_miss,
    input  logic             MEM_miss,
    input  logic             fill_done,
    output logic             fill_req,
    output logic             fill_sel,
    output logic             PC_wen,
    output logic             IF_ID_wen,
    output logic             ID_EX_wen,
    output logic             EX_MEM_wen,
    output logic             MEM_WB_wen,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] stall_count
);

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic             r_i_pend;
    logic             r_d_pend;
    logic             w_i_pend_nxt;
    logic             w_d_pend_nxt;
    logic             w_lu;
    logic [CNT_W-1:0] r_stall_count;

    hazard_detect u_hazard_detect (
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_rs_used (ID_rs_used),
        .ID_rt_used (ID_rt_used),
        .EX_MemRead (EX_MemRead),
        .EX_rd      (EX_rd),
        .lu         (w_lu)
    );

    // ------------------------------------------------------------------
    // State register and pending flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_i_pend <= 1'b0;
            r_d_pend <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_i_pend <= w_i_pend_nxt;
            r_d_pend <= w_d_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_i_pend_nxt = r_i_pend;
        w_d_pend_nxt = r_d_pend;
        case (r_state)
            RUN: begin
                // D-side wins a simultaneous miss; the I-miss is parked.
                if (MEM_miss) begin
                    w_state_nxt = DMISS;
                    if (IF_miss) w_i_pend_nxt = 1'b1;
                end else if (IF_miss) begin
                    w_state_nxt = IMISS;
                end
            end
            IMISS, DMISS: begin
                // A D-miss during an I-fill waits; the I-fill is not aborted.
                // Captured before fill_done is evaluated so a miss arriving
                // in the completion cycle is still served.
                if (r_state == IMISS && MEM_miss) w_d_pend_nxt = 1'b1;
                if (fill_done) begin
                    if (w_d_pend_nxt) begin
                        w_state_nxt  = DMISS;
                        w_d_pend_nxt = 1'b0;
                    end else if (r_i_pend) begin
                        w_state_nxt  = IMISS;
                        w_i_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = RUN;
                    end
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: combinational from inputs and state. Reset is folded in
    // so that asserting rst_n drops every enable and fill_req at once.
    // ------------------------------------------------------------------
    always_comb begin
        PC_wen       = 1'b0;
        IF_ID_wen    = 1'b0;
        ID_EX_wen    = 1'b0;
        EX_MEM_wen   = 1'b0;
        MEM_WB_wen   = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        fill_req     = 1'b0;
        fill_sel     = FILL_I;
        if (rst_n) begin
            fill_req = (r_state == IMISS) || (r_state == DMISS);
            fill_sel = (r_state == DMISS) ? FILL_D : FILL_I;
            if (MEM_miss || r_state == DMISS) begin
                // full freeze: all enables already 0
            end else if (IF_miss || r_state == IMISS || w_lu) begin
                // hold front end, inject NOP into EX, let back end drain
                ID_EX_wen    = 1'b1;
                EX_MEM_wen   = 1'b1;
                MEM_WB_wen   = 1'b1;
                ID_EX_bubble = 1'b1;
            end else begin
                PC_wen      = 1'b1;
                IF_ID_wen   = 1'b1;
                ID_EX_wen   = 1'b1;
                EX_MEM_wen  = 1'b1;
                MEM_WB_wen  = 1'b1;
                IF_ID_flush = ID_BranchTaken;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!PC_wen && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. A vector table covers the
//               single-cycle hazard/branch behaviour; hand-written sequences
//               cover misses, fill ordering, async reset and counter
//               saturation (second instance with a 4-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rsu;
        logic       rtu;
        logic       mr;
        logic [3:0] rd;
        logic       br;
        logic       im;
        logic       dm;
        logic       fd;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB wen, flush, bubble, fill_req, fill_sel}
    localparam logic [8:0] O_RST  = 9'b00000_00_00;
    localparam logic [8:0] O_RUN  = 9'b11111_00_00;
    localparam logic [8:0] O_LU   = 9'b00111_01_00;
    localparam logic [8:0] O_BR   = 9'b11111_10_00;
    localparam logic [8:0] O_DM0  = 9'b00000_00_00;
    localparam logic [8:0] O_DM   = 9'b00000_00_11;
    localparam logic [8:0] O_DMIM = 9'b00000_00_10;
    localparam logic [8:0] O_IM   = 9'b00111_01_10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ID_rs, ID_rt, EX_rd;
    logic        ID_rs_used, ID_rt_used, EX_MemRead, ID_BranchTaken;
    logic        IF_miss, MEM_miss, fill_done;
    logic        fill_req, fill_sel, PC_wen, IF_ID_wen, ID_EX_wen, EX_MEM_wen, MEM_WB_wen;
    logic        IF_ID_flush, ID_EX_bubble;
    logic [15:0] stall_count;
    logic        s_fill_req, s_fill_sel, s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_flush, s_bubble;
    logic [3:0]  s_stall_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic [8:0] sb_q[$];
    string      sb_name_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .ID_BranchTaken(ID_BranchTaken),
        .IF_miss(IF_miss), .MEM_miss(MEM_miss), .fill_done(fill_done),
        .fill_req(fill_req), .fill_sel(fill_sel),
        .PC_wen(PC_wen), .IF_ID_wen(IF_ID_wen), .ID_EX_wen(ID_EX_wen),
        .EX_MEM_wen(EX_MEM_wen), .MEM_WB_wen(MEM_WB_wen),
        .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
        .stall_count(stall_count)
    );

    pipe_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .ID_BranchTaken(ID_BranchTaken),
        .IF_miss(IF_miss), .MEM_miss(MEM_miss), .fill_done(fill_done),
        .fill_req(s_fill_req), .fill_sel(s_fill_sel),
        .PC_wen(s_pc), .IF_ID_wen(s_ifid), .ID_EX_wen(s_idex),
        .EX_MEM_wen(s_exmem), .MEM_WB_wen(s_memwb),
        .IF_ID_flush(s_flush), .ID_EX_bubble(s_bubble),
        .stall_count(s_stall_count)
    );

    function automatic in_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic rsu,
                               input logic rtu, input logic mr, input logic [3:0] rd,
                               input logic br, input logic im, input logic dm, input logic fd);
        in_t v;
        v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu; v.mr = mr;
        v.rd = rd; v.br = br; v.im = im; v.dm = dm; v.fd = fd;
        return v;
    endfunction

    task automatic set_in(input in_t v);
        ID_rs = v.rs; ID_rt = v.rt; ID_rs_used = v.rsu; ID_rt_used = v.rtu;
        EX_MemRead = v.mr; EX_rd = v.rd; ID_BranchTaken = v.br;
        IF_miss = v.im; MEM_miss = v.dm; fill_done = v.fd;
    endtask

    task automatic compare(input string name, input logic [8:0] e);
        logic [8:0] act;
        logic [8:0] act_s;
        logic [3:0] exp_s;
        act   = {PC_wen, IF_ID_wen, ID_EX_wen, EX_MEM_wen, MEM_WB_wen,
                 IF_ID_flush, ID_EX_bubble, fill_req, fill_sel};
        act_s = {s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_flush, s_bubble, s_fill_req, s_fill_sel};
        exp_s = (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt);
        n_vec++;
        if (act !== e || act_s !== e || stall_count !== 16'(exp_cnt) || s_stall_count !== exp_s) begin
            n_err++;
            $display("FAIL %s: ctrl=%b ctrl4=%b cnt=%0d cnt4=%0d, expected ctrl=%b cnt=%0d cnt4=%0d",
                     name, act, act_s, stall_count, s_stall_count, e, exp_cnt, exp_s);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1), queue the expected
    // outputs, then pop and check them at the following negedge.
    task automatic step(input in_t v, input logic [8:0] e, input string name);
        logic [8:0] exp_o;
        string      nm;
        set_in(v);
        sb_q.push_back(e);
        sb_name_q.push_back(name);
        @(negedge clk);
        exp_o = sb_q.pop_front();
        nm    = sb_name_q.pop_front();
        compare(nm, exp_o);
        if (exp_o[8] == 1'b0 && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        in_t  idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0] = '{idle,                                  O_RUN, "idle"};
        tbl[1] = '{mk(3, 0, 1, 0, 1, 3, 0, 0, 0, 0),      O_LU,  "lu_rs"};
        tbl[2] = '{mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0),      O_RUN, "lu_rd0"};
        tbl[3] = '{mk(1, 5, 1, 1, 1, 5, 0, 0, 0, 0),      O_LU,  "lu_rt"};
        tbl[4] = '{mk(1, 5, 1, 0, 1, 5, 0, 0, 0, 0),      O_RUN, "rt_unused"};
        tbl[5] = '{mk(3, 0, 1, 0, 0, 3, 0, 0, 0, 0),      O_RUN, "no_load"};
        tbl[6] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),      O_BR,  "branch"};
        tbl[7] = '{mk(3, 0, 1, 0, 1, 3, 1, 0, 0, 0),      O_LU,  "branch_lu"};
        tbl[8] = '{mk(2, 4, 1, 1, 1, 3, 0, 0, 0, 0),      O_RUN, "lu_nomatch"};
        tbl[9] = '{mk(15, 0, 1, 0, 1, 15, 0, 0, 0, 0),    O_LU,  "lu_r15"};

        rst_n = 1'b0;
        set_in(idle);
        #2;
        compare("reset_hold", O_RST);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) step(tbl[k].in, tbl[k].exp, tbl[k].name);

        // Load-use: one stall cycle, then the load has moved to MEM.
        step(tbl[1].in, O_LU, "lu_seq_stall");
        step(mk(3, 0, 1, 0, 0, 7, 0, 0, 0, 0), O_RUN, "lu_seq_release");

        // fill_done in RUN is ignored.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_RUN, "run_filldone");
        step(idle, O_RUN, "run_after_filldone");

        // D-miss, fill_done 4 cycles later: 5 frozen cycles.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DM0, "dmiss_c0");
        for (int k = 0; k < 3; k++) step(idle, O_DM, "dmiss_wait");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_DM, "dmiss_done");
        step(idle, O_RUN, "dmiss_resume");

        // Simultaneous misses: D first, then I, then RUN.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_DM0, "both_c0");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_DM, "both_dfill");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_DM, "both_ddone");
        step(idle, O_IM, "both_ifill");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_IM, "both_idone");
        step(idle, O_RUN, "both_resume");

        // D-miss arriving during an I-fill is deferred until it finishes.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_LU, "imiss_c0");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DMIM, "imiss_dmiss_arrives");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_IM, "imiss_done");
        step(idle, O_DM, "dpend_fill");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_DM, "dpend_done");
        step(idle, O_RUN, "dpend_resume");

        // Asynchronous reset in the middle of a D-fill.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DM0, "rst_dmiss_c0");
        step(idle, O_DM, "rst_dmiss_fill");
        #2;
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        compare("rst_async", O_RST);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(idle, O_RUN, "rst_release");

        // Long I-fill: 4-bit counter saturates at 15.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_LU, "sat_c0");
        for (int k = 0; k < 18; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_IM, "sat_hold");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_IM, "sat_done");
        step(idle, O_RUN, "sat_resume");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage 16-bit pipeline. It produces the write-enable (`wen`) and bubble/flush controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB from the signals those registers carry forward. It detects load-use hazards, squashes the fetched instruction on taken branches, and sequences the single-port memory fill handshake for I-cache and D-cache misses. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ID_rs`, `ID_rt`  in  4 each  source register numbers of the instruction in ID.
- `ID_rs_used`, `ID_rt_used`  in  1 each  source is actually read.
- `EX_MemRead`  in  1  instruction in EX is a load.
- `EX_rd`  in  4  destination register of the instruction in EX.
- `ID_BranchTaken`  in  1  branch resolved taken in ID.
- `IF_miss`  in  1  I-cache miss this cycle.
- `MEM_miss`  in  1  D-cache miss this cycle.
- `fill_done`  in  1  one-cycle pulse: the current fill is complete.
- `fill_req`  out  1  a fill request is outstanding (level).
- `fill_sel`  out  1  fill target: 0 = I-cache, 1 = D-cache.
- `PC_wen`, `IF_ID_wen`, `ID_EX_wen`, `EX_MEM_wen`, `MEM_WB_wen`  out  1 each  register write enables.
- `IF_ID_flush`  out  1  load NOP into IF_ID.
- `ID_EX_bubble`  out  1  load NOP (all control bits 0) into ID_EX.
- `stall_count`  out  CNT_W  cycles in which `PC_wen` was 0 (saturating).

## Operation
States: RUN, IMISS, DMISS.

Load-use hazard (`lu`) is asserted when all of the following hold:
- `EX_MemRead`
- `EX_rd != 0`
- (`ID_rs_used` and `ID_rs == EX_rd`) or (`ID_rt_used` and `ID_rt == EX_rd`)

Output priority, highest first:
1. D-miss: `MEM_miss`, or state DMISS. All five wen = 0; flush = 0; bubble = 0.
2. I-miss: `IF_miss`, or state IMISS. `PC_wen` = 0, `IF_ID_wen` = 0, `ID_EX_bubble` = 1; `EX_MEM_wen` and `MEM_WB_wen` = 1 so the back end drains.
3. `lu`: `PC_wen` = 0, `IF_ID_wen` = 0, `ID_EX_bubble` = 1, others = 1. Any branch flush that cycle is suppressed.
4. `ID_BranchTaken`: all wen = 1, `IF_ID_flush` = 1.
5. Otherwise all wen = 1; flush and bubble = 0.

Transitions:
- RUN → DMISS on `MEM_miss`.
- RUN → IMISS on `IF_miss` alone.
- If both miss in the same cycle, the D-miss is served first and `i_pend` is set.
- IMISS: a `MEM_miss` arriving sets `d_pend`; the I-fill in progress is not aborted.
- On `fill_done` the next state is:
  - DMISS if `d_pend`;
  - else IMISS if `i_pend`;
  - else RUN.
  - The consumed pending flag clears.
- `fill_req` = 1 in IMISS/DMISS. `fill_sel` = 1 iff DMISS.
- `fill_done` in RUN is ignored.

Counter:
- `stall_count` increments by 1 on every clock edge where `PC_wen` was 0.
- It saturates at all-ones and never wraps.

## Timing
- Reset (`rst_n` low, asynchronous): state = RUN, `i_pend` = `d_pend` = 0, `stall_count` = 0.
  - While reset is held, all wen = 0, flush = 0, bubble = 0, `fill_req` = 0, `fill_sel` = 0.
  - Reset during a fill abandons it; `fill_req` drops immediately.
- Hazard, flush and miss-freeze outputs are combinational from the current inputs and state, valid in the same cycle. They are consumed at the next rising edge.
- A load-use stall lasts exactly 1 cycle, since the load advances to MEM.
- A fill completes on the edge after the `fill_done` pulse. The freeze lifts in the cycle after that pulse unless another fill is pending.
- Minimum miss penalty: fill latency + 1 cycle.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum `pc_state_t` (RUN, IMISS, DMISS);
  - the constants `FILL_I` = 0 and `FILL_D` = 1.
- One sub-module: `hazard_detect`, the combinational load-use comparator producing `lu`.
- The FSM, pending flags, output mux and counter live in `pipe_ctrl`.

## Test plan
- Load-use: `EX_MemRead` = 1, `EX_rd` = 3, `ID_rs` = 3, `ID_rs_used` = 1. Expect `PC_wen` = 0, `IF_ID_wen` = 0, `ID_EX_bubble` = 1 for exactly 1 cycle; `stall_count` 0 → 1. Repeat with `EX_rd` = 0: no stall.
- Branch taken alone gives `IF_ID_flush` = 1 and all wen = 1. Branch taken together with `lu` gives the stall outputs and `IF_ID_flush` = 0.
- D-miss with `fill_done` pulsed 4 cycles later: all wen = 0 for 5 cycles; `fill_req` = 1, `fill_sel` = 1; then RUN with all wen = 1.
- `IF_miss` and `MEM_miss` in the same cycle:
  - D-fill first (`fill_sel` = 1).
  - On `fill_done`, move to IMISS (`fill_sel` = 0, `ID_EX_bubble` = 1, `EX_MEM_wen` = 1).
  - On the second `fill_done`, return to RUN.
- Pull `rst_n` low mid-DMISS: outputs go to reset values immediately; after release the state is RUN, `stall_count` = 0, `fill_req` = 0.
- Force `stall_count` near saturation (CNT_W = 4 variant): after 16 or more stall cycles it holds at 15.
